clk_ratio_gen: RTL



---
 rtl/clk_ratio_gen.sv | 101 ++++++++++
 1 files changed

// File: rtl/clk_ratio_gen.sv
// Clock-ratio generator: fractional M/D clock enable with phase shift, integer
// divider with enable, and a lock indication, all running on CLKIN.
module clk_ratio_gen #(
  parameter int CLKFX_MULTIPLY = 5,
  parameter int CLKFX_DIVIDE   = 8,
  parameter int CLKDV_DIVIDE   = 4,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic       CLKIN,
  input  logic       RST,
  input  logic       PSEN,
  input  logic       PSINCDEC,
  output logic       CLKFX_CE,
  output logic       CLKDV,
  output logic       CLKDV_CE,
  output logic       LOCKED,
  output logic       PSDONE,
  output logic [7:0] PHASE
);

  localparam int         lock_w = $clog2(LOCK_CYCLES + 1);
  localparam logic [8:0] m9     = 9'(CLKFX_MULTIPLY);
  localparam logic [8:0] d9     = 9'(CLKFX_DIVIDE);
  localparam logic [7:0] d_last = 8'(CLKFX_DIVIDE - 1);
  localparam logic [7:0] n_last = 8'(CLKDV_DIVIDE - 1);
  localparam logic [7:0] n_half = 8'(CLKDV_DIVIDE / 2);

  logic [lock_w-1:0] lock_cnt_reg;
  logic [lock_w-1:0] lock_cnt_next;
  logic              locked_reg;
  logic [7:0]        acc_reg;
  logic [7:0]        acc_adj;
  logic [7:0]        acc_next;
  logic [8:0]        sum_next;
  logic [8:0]        diff_next;
  logic              fx_ce_reg;
  logic              fx_ce_next;
  logic [7:0]        dv_cnt_reg;
  logic [7:0]        dv_cnt_next;
  logic              dv_reg;
  logic              dv_ce_reg;
  logic              psdone_reg;

  always_comb begin
    // Phase shift nudges the accumulator by one step modulo D before adding M.
    acc_adj = acc_reg;
    if (PSEN) begin
      if (PSINCDEC)
        acc_adj = (acc_reg == d_last) ? 8'd0 : acc_reg + 8'd1;
      else
        acc_adj = (acc_reg == 8'd0) ? d_last : acc_reg - 8'd1;
    end
    sum_next  = {1'b0, acc_adj} + m9;
    diff_next = sum_next - d9;
    if (sum_next >= d9) begin
      acc_next   = diff_next[7:0];
      fx_ce_next = 1'b1;
    end else begin
      acc_next   = sum_next[7:0];
      fx_ce_next = 1'b0;
    end
    dv_cnt_next   = (dv_cnt_reg == n_last) ? 8'd0 : dv_cnt_reg + 8'd1;
    lock_cnt_next = lock_cnt_reg + lock_w'(1);
  end

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
      acc_reg      <= 8'd0;
      fx_ce_reg    <= 1'b0;
      dv_cnt_reg   <= 8'd0;
      dv_reg       <= 1'b0;
      dv_ce_reg    <= 1'b0;
      psdone_reg   <= 1'b0;
    end else if (!locked_reg) begin
      // Counter freezes once locked; everything else stays quiet until then.
      lock_cnt_reg <= lock_cnt_next;
      locked_reg   <= (lock_cnt_next == lock_w'(LOCK_CYCLES));
      fx_ce_reg    <= 1'b0;
      dv_reg       <= 1'b0;
      dv_ce_reg    <= 1'b0;
      psdone_reg   <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      fx_ce_reg  <= fx_ce_next;
      dv_cnt_reg <= dv_cnt_next;
      dv_reg     <= (dv_cnt_next < n_half);
      dv_ce_reg  <= (dv_cnt_next == 8'd0);
      psdone_reg <= PSEN;
    end
  end

  assign CLKFX_CE = fx_ce_reg;
  assign CLKDV    = dv_reg;
  assign CLKDV_CE = dv_ce_reg;
  assign LOCKED   = locked_reg;
  assign PSDONE   = psdone_reg;
  assign PHASE    = acc_reg;

endmodule
